// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for a shared WIDTH-bit add/subtract
// slice. Operands are captured on a valid/ready handshake, the operation runs
// for one cycle, and a tagged result is held until the consumer takes it.
module addsub_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carryOut,
    output logic             res_overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic             last_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic             op_id;

    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] s;
    logic             c;

    // Grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_id;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready only to the granted, valid requester while idle and out of reset.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset && (state == IDLE)) begin
            req0_ready = req0_valid && !grant;
            req1_ready = req1_valid && grant;
        end
    end

    assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // Shared datapath: subtract is A + ~B + 1.
    always_comb begin
        bx     = op_b ^ {WIDTH{op_sub}};
        {c, s} = {1'b0, op_a} + {1'b0, bx} + {{WIDTH{1'b0}}, op_sub};
    end

    // Sequencer and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_id      <= 1'b1;
            op_a         <= '0;
            op_b         <= '0;
            op_sub       <= 1'b0;
            op_id        <= 1'b0;
            res_valid    <= 1'b0;
            res_id       <= 1'b0;
            res_sum      <= '0;
            res_carryOut <= 1'b0;
            res_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a   <= grant ? req1_a : req0_a;
                        op_b   <= grant ? req1_b : req0_b;
                        op_sub <= grant ? req1_sub : req0_sub;
                        op_id  <= grant;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_sum      <= s;
                    res_carryOut <= c ^ op_sub;
                    res_overflow <= (op_a[WIDTH-1] == bx[WIDTH-1]) &&
                                    (s[WIDTH-1] != op_a[WIDTH-1]);
                    res_id       <= op_id;
                    res_valid    <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        last_id   <= op_id;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: drivers push expected results, a
// negedge monitor pops and compares on every result handshake.
module tb_addsub_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, req0_sub;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_sub;
    logic [7:0] req1_a, req1_b;
    logic       res_valid, res_ready, res_id, res_carryOut, res_overflow;
    logic [7:0] res_sum;

    typedef struct packed {
        logic       id;
        logic [7:0] sum;
        logic       c;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    addsub_arbiter #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_sub     (req0_sub),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_sub     (req1_sub),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_id       (res_id),
        .res_sum      (res_sum),
        .res_carryOut (res_carryOut),
        .res_overflow (res_overflow)
    );

    always #5 clk = ~clk;

    // Cycle counter for latency and spacing checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: result handshakes against the scoreboard, plus accept->valid latency.
    logic prev_valid = 1'b0;
    logic acc_seen   = 1'b0;
    int   acc_cyc    = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            acc_seen   = 1'b0;
        end else begin
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                acc_seen = 1'b1;
                acc_cyc  = cyc;
            end
            if (res_valid && !prev_valid) begin
                checks++;
                if (!acc_seen || (cyc - acc_cyc != 2)) begin
                    errors++;
                    $display("FAIL latency got=%0d want=2 accepted=%0d", cyc - acc_cyc,
                             acc_seen);
                end
            end
            if (res_valid && res_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result id=%0d sum=%02h", res_id, res_sum);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({res_id, res_sum, res_carryOut, res_overflow} !== e) begin
                        errors++;
                        $display("FAIL result got id=%0d sum=%02h c=%0d ov=%0d want id=%0d sum=%02h c=%0d ov=%0d",
                                 res_id, res_sum, res_carryOut, res_overflow,
                                 e.id, e.sum, e.c, e.ov);
                    end
                end
            end
            prev_valid = res_valid;
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic set_req(input logic id, input logic [7:0] a, input logic [7:0] b,
                           input logic sub);
        if (id == 1'b0) begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
        end
    endtask

    task automatic push(input logic id, input logic [7:0] sum, input logic c, input logic ov);
        exp_t e;
        e.id = id; e.sum = sum; e.c = c; e.ov = ov;
        exp_q.push_back(e);
    endtask

    // Returns at the negedge on which the given requester handshakes.
    task automatic wait_accept(input logic id);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (id == 1'b0) got = req0_valid && req0_ready;
            else            got = req1_valid && req1_ready;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout id=%0d got=0 want=1", id);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
        end
    endtask

    task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic [7:0] es, input logic ec,
                          input logic eo);
        @(posedge clk); #1;
        push(id, es, ec, eo);
        set_req(id, a, b, sub);
        wait_accept(id);
        @(posedge clk); #1;
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        reset = 1'b1;
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h00; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h00; req1_b = 8'h00; req1_sub = 1'b0;

        // Reset state: no ready even with both valid, all results zero.
        repeat (3) @(negedge clk);
        check("reset_ready", {14'd0, req0_ready, req1_ready}, 16'd0);
        check("reset_res", {4'd0, res_valid, res_id, res_carryOut, res_overflow, res_sum},
              16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("idle_res", {4'd0, res_valid, res_id, res_carryOut, res_overflow, res_sum},
              16'd0);
        check("idle_ready", {14'd0, req0_ready, req1_ready}, 16'd0);

        // Basic add, then carry/overflow adds on req0, then subtracts on req1.
        run_op(1'b0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op(1'b1, 8'h03, 8'h05, 1'b1, 8'hFE, 1'b1, 1'b0);
        run_op(1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1);

        // Both valid continuously: alternate 0,1,0,1 with accepts 3 cycles apart.
        begin
            logic [7:0] a0 [2];
            logic [7:0] b0 [2];
            logic       s0 [2];
            logic [7:0] a1 [2];
            logic [7:0] b1 [2];
            logic       s1 [2];
            int n0, n1, budget, last_acc;
            a0[0] = 8'h10; b0[0] = 8'h20; s0[0] = 1'b0;
            a0[1] = 8'h40; b0[1] = 8'h10; s0[1] = 1'b1;
            a1[0] = 8'h01; b1[0] = 8'h02; s1[0] = 1'b0;
            a1[1] = 8'h05; b1[1] = 8'h06; s1[1] = 1'b1;
            n0 = 0; n1 = 0; budget = 0; last_acc = -1;
            @(posedge clk); #1;
            push(1'b0, 8'h30, 1'b0, 1'b0);
            push(1'b1, 8'h03, 1'b0, 1'b0);
            push(1'b0, 8'h30, 1'b0, 1'b0);
            push(1'b1, 8'hFF, 1'b1, 1'b0);
            set_req(1'b0, a0[0], b0[0], s0[0]);
            set_req(1'b1, a1[0], b1[0], s1[0]);
            while ((n0 < 2 || n1 < 2) && budget < 100) begin
                @(negedge clk);
                budget++;
                if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                    if (last_acc >= 0) check("tie_spacing", 16'(cyc - last_acc), 16'd3);
                    last_acc = cyc;
                end
                if (req0_valid && req0_ready) n0++;
                if (req1_valid && req1_ready) n1++;
                @(posedge clk); #1;
                if (n0 < 2) set_req(1'b0, a0[n0], b0[n0], s0[n0]);
                else        req0_valid = 1'b0;
                if (n1 < 2) set_req(1'b1, a1[n1], b1[n1], s1[n1]);
                else        req1_valid = 1'b0;
            end
            check("tie_done", 16'(budget < 100), 16'd1);
            wait_drain();
        end

        // Back-pressure: result held 5 cycles with both requesters waiting.
        begin
            int n;
            @(posedge clk); #1;
            res_ready = 1'b0;
            push(1'b0, 8'h33, 1'b0, 1'b0);
            set_req(1'b0, 8'h11, 8'h22, 1'b0);
            set_req(1'b1, 8'h0A, 8'h05, 1'b0);
            wait_accept(1'b0);
            @(posedge clk); #1;
            set_req(1'b0, 8'h01, 8'h01, 1'b0);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!res_valid && n < 20);
            for (int i = 0; i < 5; i++) begin
                check("hold_res", {4'd0, res_valid, res_id, res_carryOut, res_overflow, res_sum},
                      {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33});
                check("hold_ready", {14'd0, req0_ready, req1_ready}, 16'd0);
                if (i < 4) @(negedge clk);
            end
            @(posedge clk); #1;
            push(1'b1, 8'h0F, 1'b0, 1'b0);
            push(1'b0, 8'h02, 1'b0, 1'b0);
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            @(negedge clk);
            check("resume_ready", {14'd0, req0_ready, req1_ready}, 16'b01);
            @(posedge clk); #1;
            req1_valid = 1'b0;
            res_ready = 1'b1;
            wait_accept(1'b0);
            @(posedge clk); #1;
            req0_valid = 1'b0;
            wait_drain();
        end

        // Reset during EXEC drops the op; the next tie goes to req0.
        @(posedge clk); #1;
        set_req(1'b0, 8'h55, 8'h11, 1'b0);
        wait_accept(1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        set_req(1'b0, 8'h02, 8'h03, 1'b0);
        set_req(1'b1, 8'h09, 8'h09, 1'b0);
        @(negedge clk);
        check("rst_exec_ready", {14'd0, req0_ready, req1_ready}, 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        push(1'b0, 8'h05, 1'b0, 1'b0);
        push(1'b1, 8'h12, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_drop_valid", {15'd0, res_valid}, 16'd0);
        check("rst_tie_grant", {14'd0, req0_ready, req1_ready}, 16'b10);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_accept(1'b1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_drain();

        repeat (3) @(negedge clk);
        check("final_queue", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
Round-robin arbiter and sequencer sharing one WIDTH-bit ripple add/subtract datapath between two requesters. Each requester hands over operands with a valid/ready handshake. The block registers the operands, runs one add or subtract, and holds a tagged result until the consumer acknowledges it. It sits between two control units and the shared ALU slice and owns that slice outright.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_sub  input  1  requester 0 op select: 0 = A+B, 1 = A-B
req1_valid, req1_ready, req1_a, req1_b, req1_sub  (same as requester 0, for requester 1)
res_valid  output  1  result held and valid
res_ready  input  1  consumer accepts result
res_id  output  1  index of the requester that issued the result
res_sum  output  WIDTH  result, modulo 2^WIDTH
res_carryOut  output  1  add: carry out; sub: borrow (1 iff A<B unsigned)
res_overflow  output  1  two's-complement signed overflow

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. All state is registered.
- Reset values: state=IDLE, res_valid=0, res_sum=0, res_carryOut=0, res_overflow=0, res_id=0, last_id=1.
- The ready outputs are combinational from state and grant. Both are 0 while reset is high.
- FSM states are IDLE, EXEC and RESP.
- IDLE, grant selection:
  - Only one reqN_valid high: grant goes to that requester.
  - Both valid: grant goes to the requester that is not last_id.
  - last_id resets to 1, so the first tie goes to requester 0.
- IDLE, handshake:
  - reqN_ready = 1 only for the granted requester. The other ready is 0.
  - Both readys are 0 when neither valid is high.
  - On valid&&ready: capture A, B, sub and id into operand registers, then go to EXEC.
- Grant is re-evaluated every IDLE cycle. A requester must hold valid and its operands stable until accepted.
- EXEC (exactly 1 cycle):
  - bx = B XOR {WIDTH{sub}}.
  - {c, s} = A + bx + sub, a (WIDTH+1)-bit sum.
  - Register res_sum = s, res_carryOut = c XOR sub, res_id = id.
  - res_overflow = (A[msb]==bx[msb]) && (s[msb]!=A[msb]).
  - Set res_valid=1 and go to RESP.
- RESP:
  - res_valid=1. All res_* outputs are held stable. Both readys are 0.
  - On res_ready: clear res_valid, set last_id=id, go to IDLE.
  - res_sum, res_carryOut, res_overflow and res_id keep their last values after res_valid falls.
- Latency: accept edge at cycle T, then res_valid=1 from cycle T+2.
- Throughput: at most one op per 3 cycles with res_ready held high. The earliest next accept is the cycle after the result handshake.
- Reset asserted in any state:
  - Any in-flight op is dropped and no response is issued.
  - last_id returns to 1.
  - No ready is asserted during the reset cycle.
- res_ready high while res_valid is 0 is ignored.

Test Plan:
1. Reset, then req0 add 0x05+0x03. Required: res_valid rises 2 cycles after accept; res_id=0, res_sum=0x08, res_carryOut=0, res_overflow=0. All res_* are 0 before the first op.
2. Subtracts on req1:
   - 0x03-0x05 -> res_sum=0xFE, res_carryOut=1, res_overflow=0.
   - 0x80-0x01 -> res_sum=0x7F, res_carryOut=0, res_overflow=1.
3. Adds on req0:
   - 0xFF+0x01 -> res_sum=0x00, res_carryOut=1, res_overflow=0.
   - 0x7F+0x01 -> res_sum=0x80, res_carryOut=0, res_overflow=1.
4. Both valid continuously for 4 ops, res_ready=1. Required: res_id sequence 0,1,0,1, and accepts spaced 3 cycles apart.
5. res_ready held 0 for 5 cycles in RESP while both valid are high. Required: res_* stable, both readys 0, no accept; accept resumes the cycle after res_ready pulses.
6. reset pulsed during EXEC. Required: res_valid never rises for the dropped op. A following simultaneous req0/req1 tie grants req0.
